// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle core and mem_responder.
// The master drives the request; the slave returns the strobed response.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata,
        input  err,
        input  busy
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata,
        output err,
        output busy
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed unified memory answering one request at a time after WAIT_CYCLES wait states.
// Optional MEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [31:0]             mem_q [Depth];

    logic                    commit;
    logic                    acc_we;
    logic [31:0]             acc_addr;
    logic [31:0]             acc_wdata;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic                    acc_mis;
    logic                    unused_addr;

    // With no wait states the commit shares the accepting edge, so take the live request then.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == StIdle) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
        end
        acc_idx = acc_addr[DEPTH_LOG2+1:2];
`ifdef MEM_ALIGN_CHECK_EN
        acc_mis = (acc_addr[1:0] != 2'b00);
`else
        acc_mis = 1'b0;
`endif
    end

    assign unused_addr = ^acc_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read-before-write: rdata captures the old word on the commit edge.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            rdata_d = acc_mis ? 32'd0 : mem_q[acc_idx];
            err_d   = acc_mis;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == StIdle && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
        end
    end

    // Storage is not reset; a reset on the commit edge cancels the write.
    always_ff @(posedge clk) begin
        if (rst && commit && acc_we && !acc_mis) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign bus.ready = (state_q == StResp);
    assign bus.busy  = (state_q != StIdle);
    assign bus.err   = bus.ready & err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an array-based memory model.
// A second instance covers the zero-wait-state configuration.
module tb_mem_responder;
    localparam int unsigned WC    = 2;
    localparam int unsigned DL    = 8;
    localparam int unsigned DEPTH = 2 ** DL;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [31:0] ref_mem [DEPTH];

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    mem_responder #(
        .DEPTH_LOG2  (DL),
        .WAIT_CYCLES (WC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mem_responder #(
        .DEPTH_LOG2  (4),
        .WAIT_CYCLES (0)
    ) u_dut_nowait (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Starts in an IDLE cycle and returns in the cycle after ready.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit hold, input bit chk_rd,
                           output logic [31:0] got_rd, output logic got_err);
        int          idx;
        bit          mis;
        logic [31:0] exp_rd;
        idx = int'((addr >> 2) % DEPTH);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (addr % 4) != 0;
`endif
        exp_rd = mis ? 32'd0 : ref_mem[idx];
        bus0.req   = 1'b1;
        bus0.we    = we;
        bus0.addr  = addr;
        bus0.wdata = wdata;
        check("idle_busy", 32'(bus0.busy), 32'd0);
        check("idle_ready", 32'(bus0.ready), 32'd0);
        for (int k = 1; k <= int'(WC) + 1; k++) begin
            @(posedge clk);
            #1;
            if (!hold) bus0.req = 1'b0;
            check("busy", 32'(bus0.busy), 32'd1);
            check("ready", 32'(bus0.ready), (k == int'(WC) + 1) ? 32'd1 : 32'd0);
        end
        got_rd  = bus0.rdata;
        got_err = bus0.err;
        if (chk_rd) check("rdata", bus0.rdata, exp_rd);
        check("err", 32'(bus0.err), 32'(mis));
        if (we && !mis) ref_mem[idx] = wdata;
        @(posedge clk);
        #1;
        check("post_ready", 32'(bus0.ready), 32'd0);
        check("post_busy", 32'(bus0.busy), 32'd0);
    endtask

    task automatic idle(input int n);
        bus0.req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("gap_ready", 32'(bus0.ready), 32'd0);
            check("gap_busy", 32'(bus0.busy), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] old;
        logic [31:0] a;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0;
        bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 32'd0; bus1.wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus0.ready), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_err", 32'(bus0.err), 32'd0);
        check("rst_rdata", bus0.rdata, 32'd0);
        check("rst_rdata_nw", bus1.rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill memory so every later read has a known expected value.
        for (int i = 0; i < int'(DEPTH); i++) begin
            run_txn(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, rd, er);
        end

        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, rd, er);
        run_txn(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, rd, er);
        check("deadbeef", rd, 32'hDEADBEEF);
        run_txn(1'b1, 32'h10, 32'h01020304, 1'b1, 1'b1, rd, er);
        check("rbw_old", rd, 32'hDEADBEEF);

        run_txn(1'b1, 32'h404, 32'h12345678, 1'b0, 1'b1, rd, er);
        run_txn(1'b0, 32'h004, 32'h0, 1'b0, 1'b1, rd, er);
        check("wrap", rd, 32'h12345678);

        old = ref_mem[8];
        run_txn(1'b1, 32'h21, 32'hFFFFFFFF, 1'b0, 1'b1, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_err", 32'(er), 32'd1);
        check("mis_rdata", rd, 32'd0);
        run_txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b1, rd, er);
        check("mis_keep", rd, old);
`else
        run_txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b1, rd, er);
        check("noalign_rd", rd, 32'hFFFFFFFF);
`endif
        check("align_rd_err", 32'(er), 32'd0);

        old = ref_mem[12];
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h30; bus0.wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        bus0.req = 1'b0;
        check("mid_busy", 32'(bus0.busy), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_ready", 32'(bus0.ready), 32'd0);
        check("mid_busy_rst", 32'(bus0.busy), 32'd0);
        check("mid_rdata", bus0.rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_txn(1'b0, 32'h30, 32'h0, 1'b0, 1'b1, rd, er);
        check("mid_abandon", rd, old);

        for (int t = 0; t < 300; t++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(1)), a, $urandom, 1'($urandom_range(1)), 1'b1, rd, er);
            if ($urandom_range(2) == 0) idle(int'($urandom_range(2)) + 1);
        end
        idle(1);

        bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 32'h8; bus1.wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus1.req = 1'b0;
        check("nw_wr_ready", 32'(bus1.ready), 32'd1);
        check("nw_wr_busy", 32'(bus1.busy), 32'd1);
        @(posedge clk);
        #1;
        check("nw_idle_ready", 32'(bus1.ready), 32'd0);
        check("nw_idle_busy", 32'(bus1.busy), 32'd0);
        bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h48;
        @(posedge clk);
        #1;
        bus1.req = 1'b0;
        check("nw_rd_ready", 32'(bus1.ready), 32'd1);
        check("nw_rd_busy", 32'(bus1.busy), 32'd1);
        check("nw_rd_rdata", bus1.rdata, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("nw_end_busy", 32'(bus1.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
